// File: rtl/flood_pkg.sv
// Shared constants, state encoding and clamp/LFSR helpers for the flood game blocks.
// Latency: n/a (package only).
// Backpressure: n/a.
package flood_pkg;

    localparam int MAX_SIZE   = 26;
    localparam int MIN_SIZE   = 2;
    localparam int ADDR_W     = 10;
    localparam int COLOR_W    = 3;
    localparam int MIN_COLORS = 3;
    localparam int MAX_COLORS = 8;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Board edges the selection stage is allowed to offer.
    localparam logic [4:0] LEGAL_SIZES [7] = '{5'd2, 5'd6, 5'd10, 5'd14, 5'd18, 5'd22, 5'd26};

    function automatic logic [4:0] clamp_size(input logic [4:0] s);
        if (s < 5'(MIN_SIZE)) return 5'(MIN_SIZE);
        if (s > 5'(MAX_SIZE)) return 5'(MAX_SIZE);
        return s;
    endfunction

    function automatic logic [3:0] clamp_colors(input logic [3:0] c);
        if (c < 4'(MIN_COLORS)) return 4'(MIN_COLORS);
        if (c > 4'(MAX_COLORS)) return 4'(MAX_COLORS);
        return c;
    endfunction

    // Galois step, shift right; a non-zero state never maps to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/board_init_if.sv
// Request/response and board-RAM write bundle between selection stage, board_init and RAM.
// Latency: n/a (wiring only).
// Backpressure: none; the RAM must accept one write per cycle.
interface board_init_if;
    import flood_pkg::*;

    logic                 INITIALIZE_BOARD;
    logic [4:0]           SIZE;
    logic [3:0]           COLOR_NUM;
    logic [15:0]          SEED_IN;
    logic                 BOARD_READY;
    logic                 BUSY;
    logic                 WR_EN;
    logic [ADDR_W-1:0]    WR_ADDR;
    logic [COLOR_W-1:0]   WR_DATA;
    logic [COLOR_W-1:0]   FIRST_COLOR;

    modport master (
        output INITIALIZE_BOARD, SIZE, COLOR_NUM, SEED_IN,
        input  BOARD_READY, BUSY, WR_EN, WR_ADDR, WR_DATA, FIRST_COLOR
    );

    modport slave (
        input  INITIALIZE_BOARD, SIZE, COLOR_NUM, SEED_IN,
        output BOARD_READY, BUSY, WR_EN, WR_ADDR, WR_DATA, FIRST_COLOR
    );

endinterface

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with synchronous load and step enable.
// Latency: new state visible one cycle after load/step.
// Backpressure: none; holds state when step is low.
module lfsr16
    import flood_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        step,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Load has priority over stepping.
    always_comb begin
        state_d = state_q;
        if (load)      state_d = load_val;
        else if (step) state_d = lfsr_next(state_q);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RESET_VAL;
        else        state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/board_init.sv
// Fills the board RAM with LFSR-derived colours, one cell per cycle, then raises BOARD_READY.
// Latency: first write 2 cycles after the request is sampled; SIZE_c^2 writes; ready 1 cycle after.
// Backpressure: none; dropping INITIALIZE_BOARD aborts at the next edge.
module board_init
    import flood_pkg::*;
(
    input  logic        MASTER_CLOCK,
    input  logic        RESET_N,
    board_init_if.slave bd
);

    state_t               state_q, state_d;
    logic [4:0]           row_q, row_d, col_q, col_d, size_q, size_d;
    logic [3:0]           colors_q, colors_d;
    logic                 wr_en_q, wr_en_d, ready_q, ready_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [COLOR_W-1:0]   wr_data_q, wr_data_d, first_color_q, first_color_d;

    logic                 init;
    logic                 lfsr_load, lfsr_step;
    logic [15:0]          lfsr_state, lfsr_seed_val;
    logic [11:0]          prod;
    logic [COLOR_W-1:0]   cell_color;
    logic                 last_col, last_cell;
    logic                 lfsr_hi_unused;

    assign init          = bd.INITIALIZE_BOARD;
    assign lfsr_seed_val = (bd.SEED_IN == 16'h0) ? LFSR_SEED : bd.SEED_IN;
    // Scaling the low byte by the colour count keeps the result in 0..colors-1.
    assign prod          = 12'(lfsr_state[7:0]) * 12'(colors_q);
    assign cell_color    = prod[8 +: COLOR_W];
    assign lfsr_hi_unused = ^{lfsr_state[15:8], prod[11]};
    assign last_col      = (col_q == size_q - 5'd1);
    assign last_cell     = last_col && (row_q == size_q - 5'd1);

    lfsr16 u_lfsr (
        .clk      (MASTER_CLOCK),
        .rst_n    (RESET_N),
        .load     (lfsr_load),
        .load_val (lfsr_seed_val),
        .step     (lfsr_step),
        .state    (lfsr_state)
    );

    // State register.
    always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state: any loss of the request returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (init) state_d = LATCH;
            LATCH: state_d = init ? FILL : IDLE;
            FILL:  if (!init)        state_d = IDLE;
                   else if (last_cell) state_d = DONE;
            DONE:  if (!init) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values per state.
    always_comb begin
        row_d         = row_q;
        col_d         = col_q;
        size_d        = size_q;
        colors_d      = colors_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        first_color_d = first_color_q;
        ready_d       = 1'b0;
        lfsr_load     = 1'b0;
        lfsr_step     = 1'b0;
        case (state_q)
            LATCH: begin
                size_d    = clamp_size(bd.SIZE);
                colors_d  = clamp_colors(bd.COLOR_NUM);
                row_d     = 5'd0;
                col_d     = 5'd0;
                lfsr_load = 1'b1;
            end
            FILL: begin
                if (init) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {row_q, col_q};
                    wr_data_d = cell_color;
                    if (row_q == 5'd0 && col_q == 5'd0) first_color_d = cell_color;
                    lfsr_step = 1'b1;
                    if (last_col) begin
                        col_d = 5'd0;
                        row_d = row_q + 5'd1;
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
            DONE:    ready_d = init;
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            row_q         <= 5'd0;
            col_q         <= 5'd0;
            size_q        <= 5'(MIN_SIZE);
            colors_q      <= 4'(MIN_COLORS);
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            first_color_q <= '0;
            ready_q       <= 1'b0;
        end else begin
            row_q         <= row_d;
            col_q         <= col_d;
            size_q        <= size_d;
            colors_q      <= colors_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            first_color_q <= first_color_d;
            ready_q       <= ready_d;
        end
    end

    assign bd.WR_EN       = wr_en_q;
    assign bd.WR_ADDR     = wr_addr_q;
    assign bd.WR_DATA     = wr_data_q;
    assign bd.FIRST_COLOR = first_color_q;
    assign bd.BOARD_READY = ready_q;
    assign bd.BUSY        = (state_q == LATCH) || (state_q == FILL);

endmodule

// File: tb/tb_board_init.sv
// Directed bench for board_init: reset, small/large fills, abort, clamping, re-request.
// Latency: n/a.
// Backpressure: n/a.
module tb_board_init;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    board_init_if bus();

    board_init dut (
        .MASTER_CLOCK (clk),
        .RESET_N      (rst_n),
        .bd           (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [9:0] cap_addr[$];
    logic [2:0] cap_data[$];
    logic [9:0] exp_addr[$];
    logic [2:0] exp_data[$];
    int         first_cyc, ready_cyc;
    logic       wr_at_ready;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [2:0] cdata(input logic [15:0] s, input int k);
        int p;
        p = int'(s[7:0]) * k;
        return 3'(p >> 8);
    endfunction

    // Reference board contents in write order.
    task automatic build_model(input int n, input int k, input logic [15:0] seed);
        logic [15:0] s;
        exp_addr.delete();
        exp_data.delete();
        s = (seed == 16'h0) ? 16'hACE1 : seed;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                exp_addr.push_back(10'(r * 32 + c));
                exp_data.push_back(cdata(s, k));
                s = lstep(s);
            end
        end
    endtask

    task automatic set_req(input logic [4:0] s, input logic [3:0] c, input logic [15:0] sd);
        bus.SIZE      = s;
        bus.COLOR_NUM = c;
        bus.SEED_IN   = sd;
    endtask

    // Raise the request and record writes until BOARD_READY or the budget runs out.
    task automatic capture(input int budget);
        cap_addr.delete();
        cap_data.delete();
        first_cyc   = -1;
        ready_cyc   = -1;
        wr_at_ready = 1'bx;
        bus.INITIALIZE_BOARD = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (bus.WR_EN) begin
                if (first_cyc < 0) first_cyc = c;
                cap_addr.push_back(bus.WR_ADDR);
                cap_data.push_back(bus.WR_DATA);
            end
            if (bus.BOARD_READY) begin
                ready_cyc   = c;
                wr_at_ready = bus.WR_EN;
                break;
            end
        end
    endtask

    task automatic drop_req();
        bus.INITIALIZE_BOARD = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [4:0] outs;
        bus.INITIALIZE_BOARD = 1'b0;
        set_req(5'd0, 4'd0, 16'h0);
        rst_n = 1'b0;
        tick();
        tick();
        outs = {bus.WR_EN, bus.BOARD_READY, bus.BUSY, |bus.FIRST_COLOR, |bus.WR_ADDR};
        tests_run++;
        if (outs !== 5'b0) begin tests_failed++; $display("FAIL reset_outputs got %b want 00000", outs); end
        tests_run++;
        if (dut.state_q !== flood_pkg::IDLE) begin tests_failed++; $display("FAIL reset_state got %0d want 0", dut.state_q); end
        rst_n = 1'b1;
        tick();
        // Reset in the middle of a fill.
        set_req(5'd14, 4'd5, 16'h1234);
        bus.INITIALIZE_BOARD = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        tests_run++;
        if (bus.WR_EN !== 1'b1 || bus.FIRST_COLOR !== 3'd1) begin
            tests_failed++; $display("FAIL midfill_pre wr_en %b first %0d want 1 1", bus.WR_EN, bus.FIRST_COLOR);
        end
        #2 rst_n = 1'b0;
        #1;
        outs = {bus.WR_EN, bus.BOARD_READY, bus.BUSY, |bus.FIRST_COLOR, 1'b0};
        tests_run++;
        if (outs !== 5'b0) begin tests_failed++; $display("FAIL midfill_reset got %b want 00000", outs); end
        tests_run++;
        if (dut.state_q !== flood_pkg::IDLE) begin tests_failed++; $display("FAIL midfill_state got %0d want 0", dut.state_q); end
        bus.INITIALIZE_BOARD = 1'b0;
        tick();
        rst_n = 1'b1;
        begin
            int nw = 0;
            for (int i = 0; i < 5; i++) begin tick(); if (bus.WR_EN || bus.BUSY) nw++; end
            tests_run++;
            if (nw !== 0) begin tests_failed++; $display("FAIL post_reset_activity got %0d want 0", nw); end
        end
    endtask

    task automatic test_small();
        set_req(5'd2, 4'd8, 16'h0001);
        build_model(2, 8, 16'h0001);
        capture(50);
        tests_run++;
        if (cap_addr.size() !== 4) begin tests_failed++; $display("FAIL small_count got %0d want 4", cap_addr.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [9:0] a;
            a = (i < cap_addr.size()) ? cap_addr[i] : 10'bx;
            tests_run++;
            if (a !== exp_addr[i]) begin tests_failed++; $display("FAIL small_addr%0d got %0d want %0d", i, a, exp_addr[i]); end
        end
        tests_run++;
        if (cap_data.size() == 0 || cap_data[0] !== 3'd0) begin tests_failed++; $display("FAIL small_data0 got %0d want 0", (cap_data.size() != 0) ? cap_data[0] : 3'bx); end
        tests_run++;
        if (first_cyc !== 3) begin tests_failed++; $display("FAIL small_first_wr got %0d want 3", first_cyc); end
        tests_run++;
        if (ready_cyc !== 7) begin tests_failed++; $display("FAIL small_ready_cycle got %0d want 7", ready_cyc); end
        tests_run++;
        if (wr_at_ready !== 1'b0) begin tests_failed++; $display("FAIL small_wr_at_ready got %b want 0", wr_at_ready); end
        tests_run++;
        if (bus.FIRST_COLOR !== 3'd0) begin tests_failed++; $display("FAIL small_first_color got %0d want 0", bus.FIRST_COLOR); end
        bus.INITIALIZE_BOARD = 1'b0;
        tick();
        tests_run++;
        if (bus.BOARD_READY !== 1'b0) begin tests_failed++; $display("FAIL small_ready_drop got %b want 0", bus.BOARD_READY); end
        tick();
    endtask

    task automatic test_large();
        int maxd = 0;
        int bad  = 0;
        set_req(5'd26, 4'd3, 16'h0000);
        build_model(26, 3, 16'h0000);
        capture(800);
        tests_run++;
        if (cap_addr.size() !== 676) begin tests_failed++; $display("FAIL large_count got %0d want 676", cap_addr.size()); end
        tests_run++;
        if (cap_addr.size() == 0 || cap_addr[$] !== 10'd825) begin tests_failed++; $display("FAIL large_last_addr got %0d want 825", (cap_addr.size() != 0) ? cap_addr[$] : 10'bx); end
        foreach (cap_data[i]) begin
            if (int'(cap_data[i]) > maxd) maxd = int'(cap_data[i]);
            if (i >= exp_data.size() || cap_data[i] !== exp_data[i] || cap_addr[i] !== exp_addr[i]) bad++;
        end
        tests_run++;
        if (maxd > 2) begin tests_failed++; $display("FAIL large_max_data got %0d want <=2", maxd); end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL large_seq_mismatches got %0d want 0", bad); end
        tests_run++;
        if (bus.FIRST_COLOR !== 3'd2) begin tests_failed++; $display("FAIL large_first_color got %0d want 2", bus.FIRST_COLOR); end
        drop_req();
    endtask

    task automatic test_abort();
        int nw = 0;
        int late = 0;
        set_req(5'd14, 4'd5, 16'h1234);
        bus.INITIALIZE_BOARD = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.WR_EN) nw++;
            if (nw == 10) break;
        end
        tests_run++;
        if (nw !== 10) begin tests_failed++; $display("FAIL abort_prewrites got %0d want 10", nw); end
        bus.INITIALIZE_BOARD = 1'b0;
        tick();
        tests_run++;
        if (bus.WR_EN !== 1'b0 || bus.BUSY !== 1'b0) begin
            tests_failed++; $display("FAIL abort_stop wr_en %b busy %b want 0 0", bus.WR_EN, bus.BUSY);
        end
        for (int i = 0; i < 30; i++) begin tick(); if (bus.WR_EN || bus.BOARD_READY) late++; end
        tests_run++;
        if (late !== 0) begin tests_failed++; $display("FAIL abort_late_activity got %0d want 0", late); end
        tests_run++;
        if (bus.FIRST_COLOR !== 3'd1) begin tests_failed++; $display("FAIL abort_first_color got %0d want 1", bus.FIRST_COLOR); end
    endtask

    task automatic test_clamp();
        int maxd = 0;
        int bad  = 0;
        set_req(5'd31, 4'd1, 16'h00FF);
        build_model(26, 3, 16'h00FF);
        capture(800);
        tests_run++;
        if (cap_addr.size() !== 676) begin tests_failed++; $display("FAIL clamp_count got %0d want 676", cap_addr.size()); end
        foreach (cap_data[i]) begin
            if (int'(cap_data[i]) > maxd) maxd = int'(cap_data[i]);
            if (i >= exp_data.size() || cap_data[i] !== exp_data[i] || cap_addr[i] !== exp_addr[i]) bad++;
        end
        tests_run++;
        if (maxd > 2) begin tests_failed++; $display("FAIL clamp_max_data got %0d want <=2", maxd); end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL clamp_seq_mismatches got %0d want 0", bad); end
        drop_req();
    endtask

    task automatic test_back_to_back();
        logic [2:0] saved[$];
        int bad = 0;
        int extra = 0;
        int not_ready = 0;
        set_req(5'd6, 4'd6, 16'hBEEF);
        build_model(6, 6, 16'hBEEF);
        capture(100);
        saved = cap_data;
        foreach (cap_data[i]) if (i >= exp_data.size() || cap_data[i] !== exp_data[i]) bad++;
        tests_run++;
        if (cap_data.size() !== 36 || bad !== 0) begin tests_failed++; $display("FAIL b2b_first_fill count %0d bad %0d want 36 0", cap_data.size(), bad); end
        set_req(5'd10, 4'd4, 16'h5555);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.WR_EN) extra++;
            if (!bus.BOARD_READY) not_ready++;
        end
        tests_run++;
        if (extra !== 0 || not_ready !== 0) begin tests_failed++; $display("FAIL b2b_hold writes %0d ready_low %0d want 0 0", extra, not_ready); end
        bus.INITIALIZE_BOARD = 1'b0;
        tick();
        tests_run++;
        if (bus.BOARD_READY !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_drop got %b want 0", bus.BOARD_READY); end
        set_req(5'd6, 4'd6, 16'hBEEF);
        capture(100);
        bad = 0;
        foreach (cap_data[i]) if (i >= saved.size() || cap_data[i] !== saved[i] || cap_addr[i] !== exp_addr[i]) bad++;
        tests_run++;
        if (cap_data.size() !== 36 || bad !== 0) begin tests_failed++; $display("FAIL b2b_second_fill count %0d bad %0d want 36 0", cap_data.size(), bad); end
        tests_run++;
        if (bus.FIRST_COLOR !== exp_data[0]) begin tests_failed++; $display("FAIL b2b_first_color got %0d want %0d", bus.FIRST_COLOR, exp_data[0]); end
        drop_req();
    endtask

    initial begin
        bus.INITIALIZE_BOARD = 1'b0;
        bus.SIZE      = 5'd0;
        bus.COLOR_NUM = 4'd0;
        bus.SEED_IN   = 16'h0;
        test_reset();
        test_small();
        test_large();
        test_abort();
        test_clamp();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
